// File: rtl/ring_state_decoder.sv
// -----------------------------------------------------------------------------
// ring_state_decoder
//
// Observer for an N-state one-hot ring controller. On every clock edge where
// `step` is high, it samples the controller's one-hot state bus. From those
// samples it recovers:
//   - the binary position,
//   - the direction of the last move, and
//   - a signed net revolution count.
// It also detects malformed encodings and illegal transitions.
//
// Optional build macro:
//   RING_HOLD_ERR_EN - when defined, sampling the same state twice in TRACK
//                      (a "hold") is reported as an illegal jump.
//                      When undefined, a hold is legal and silent.
//
// Parameters:
//   N      ring length / one-hot width (2..8)
//   REV_W  revolution counter width
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous reset, active-low
//   step      sample strobe; `ring` is evaluated only when step==1
//   ring      one-hot state bus, bit 0 = first state
//   pos       binary index of the last legally sampled state
//   dir       1 = last move forward, 0 = reverse
//   moved     one-cycle pulse per legal single-step move
//   revs      signed (two's complement) net revolutions, wraps
//   locked    a legal reference state has been captured
//   err       sticky fault flag
//   err_code  bit0 = not one-hot seen, bit1 = illegal jump seen
//
// All outputs are registered; there is no combinational path from the
// inputs to the outputs.
// -----------------------------------------------------------------------------
module ring_state_decoder #(
    parameter int N     = 5,
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [N-1:0]     ring,
    output logic [2:0]       pos,
    output logic             dir,
    output logic             moved,
    output logic [REV_W-1:0] revs,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    state_t           state_reg,    state_next;
    logic [2:0]       pos_reg,      pos_next;
    logic             dir_reg,      dir_next;
    logic             moved_reg,    moved_next;
    logic [REV_W-1:0] revs_reg,     revs_next;
    logic             locked_reg,   locked_next;
    logic             err_reg,      err_next;
    logic [1:0]       err_code_reg, err_code_next;

    // ------------------------------------------------------------------
    // Sample decode.
    // Each set bit contributes its own index. OR-ing these contributions
    // together yields the sample index q whenever the sample is one-hot.
    // ------------------------------------------------------------------
    logic [2:0] idx_term [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_idx
            assign idx_term[gi] = ring[gi] ? 3'(gi) : 3'd0;
        end
    endgenerate

    logic [3:0] ones_cnt;
    logic [2:0] q_idx;
    logic       one_hot;

    always_comb begin
        ones_cnt = 4'd0;
        q_idx    = 3'd0;
        for (int i = 0; i < N; i++) begin
            ones_cnt = ones_cnt + {3'd0, ring[i]};
            q_idx    = q_idx | idx_term[i];
        end
        one_hot = (ones_cnt == 4'd1);
    end

    // ------------------------------------------------------------------
    // Neighbour indices of the current position, modulo N.
    // For N=2 these two indices coincide. Forward is tested first, so such
    // a move decodes as forward.
    // ------------------------------------------------------------------
    logic [2:0] fwd_idx;
    logic [2:0] rev_idx;
    logic       is_fwd;
    logic       is_rev;
    logic       is_hold;
    logic       hold_bad;
    logic       jump_bad;

    always_comb begin
        fwd_idx = (pos_reg == LAST_IDX) ? 3'd0 : pos_reg + 3'd1;
        rev_idx = (pos_reg == 3'd0) ? LAST_IDX : pos_reg - 3'd1;
        is_fwd  = (q_idx == fwd_idx);
        is_rev  = !is_fwd && (q_idx == rev_idx);
        is_hold = (q_idx == pos_reg);
`ifdef RING_HOLD_ERR_EN
        hold_bad = 1'b1;
`else
        hold_bad = 1'b0;
`endif
        // Meaningful only when the sample is one-hot.
        jump_bad = !is_fwd && !is_rev && (!is_hold || hold_bad);
    end

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        dir_next      = dir_reg;
        moved_next    = 1'b0;
        revs_next     = revs_reg;
        locked_next   = locked_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;

        unique case (state_reg)
            ST_SYNC: begin
                // Non-one-hot samples are ignored until a clean lock.
                if (step && one_hot) begin
                    pos_next    = q_idx;
                    locked_next = 1'b1;
                    state_next  = ST_TRACK;
                end
            end

            ST_TRACK: begin
                if (step) begin
                    if (!one_hot) begin
                        state_next    = ST_FAULT;
                        err_next      = 1'b1;
                        locked_next   = 1'b0;
                        err_code_next = err_code_reg | 2'b01;
                    end else if (jump_bad) begin
                        state_next    = ST_FAULT;
                        err_next      = 1'b1;
                        locked_next   = 1'b0;
                        err_code_next = err_code_reg | 2'b10;
                    end else if (is_fwd) begin
                        pos_next   = q_idx;
                        dir_next   = 1'b1;
                        moved_next = 1'b1;
                        // Wrapping from the last state to state 0
                        // completes a forward revolution.
                        if (pos_reg == LAST_IDX) begin
                            revs_next = revs_reg + REV_W'(1);
                        end
                    end else if (is_rev) begin
                        pos_next   = q_idx;
                        dir_next   = 1'b0;
                        moved_next = 1'b1;
                        // Wrapping from state 0 to the last state
                        // undoes one revolution.
                        if (pos_reg == 3'd0) begin
                            revs_next = revs_reg - REV_W'(1);
                        end
                    end
                    // Otherwise: a legal hold. Nothing changes.
                end
            end

            ST_FAULT: begin
                // Position, direction and revolution count stay frozen.
                // New faults only accumulate into err_code.
                if (step) begin
                    if (!one_hot) begin
                        err_code_next = err_code_reg | 2'b01;
                    end else if (jump_bad) begin
                        err_code_next = err_code_reg | 2'b10;
                    end
                end
            end

            default: begin
                state_next = ST_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Reset dominates step.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_SYNC;
            pos_reg      <= 3'd0;
            dir_reg      <= 1'b1;
            moved_reg    <= 1'b0;
            revs_reg     <= '0;
            locked_reg   <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'b00;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            dir_reg      <= dir_next;
            moved_reg    <= moved_next;
            revs_reg     <= revs_next;
            locked_reg   <= locked_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    assign pos      = pos_reg;
    assign dir      = dir_reg;
    assign moved    = moved_reg;
    assign revs     = revs_reg;
    assign locked   = locked_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_ring_state_decoder.sv
// -----------------------------------------------------------------------------
// tb_ring_state_decoder
//
// Directed self-checking bench for ring_state_decoder (N=5, REV_W=8).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit after the edge that consumed the stimulus.
// -----------------------------------------------------------------------------
module tb_ring_state_decoder;

    localparam int N     = 5;
    localparam int REV_W = 8;

    logic             clk;
    logic             rst;
    logic             step;
    logic [N-1:0]     ring;
    logic [2:0]       pos;
    logic             dir;
    logic             moved;
    logic [REV_W-1:0] revs;
    logic             locked;
    logic             err;
    logic [1:0]       err_code;

    int n_total;
    int n_bad;

    ring_state_decoder #(.N(N), .REV_W(REV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .ring     (ring),
        .pos      (pos),
        .dir      (dir),
        .moved    (moved),
        .revs     (revs),
        .locked   (locked),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One edge with step high and the given sample.
    task automatic apply(input logic [N-1:0] r);
        ring = r;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        $display("step ring=%b -> pos=%0d dir=%0b moved=%0b revs=%0d locked=%0b err=%0b code=%b",
                 r, pos, dir, moved, $signed(revs), locked, err, err_code);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        step = 1'b0;
        ring = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle();
        step = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_pos"},    32'(pos),      32'd0);
        check_val({tag, "_dir"},    32'(dir),      32'd1);
        check_val({tag, "_moved"},  32'(moved),    32'd0);
        check_val({tag, "_revs"},   32'(revs),     32'd0);
        check_val({tag, "_locked"}, 32'(locked),   32'd0);
        check_val({tag, "_err"},    32'(err),      32'd0);
        check_val({tag, "_code"},   32'(err_code), 32'd0);
    endtask

    logic [N-1:0] fwd_seq [5];
    logic [2:0]   fwd_pos [5];
    logic [N-1:0] rev_seq [5];
    logic [2:0]   rev_pos [5];
    int           moved_cnt;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b0;
        step    = 1'b0;
        ring    = '0;

        fwd_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        fwd_pos = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        rev_seq = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        rev_pos = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

        // ---------------- reset values ----------------
        do_reset();
        check_reset_outs("rst");

        // A non-one-hot sample in SYNC is ignored.
        apply(5'b00110);
        check_val("sync_bad_locked", 32'(locked), 32'd0);
        check_val("sync_bad_err",    32'(err),    32'd0);

        // ---------------- lock ----------------
        apply(5'b00001);
        check_val("lock_locked", 32'(locked), 32'd1);
        check_val("lock_pos",    32'(pos),    32'd0);
        check_val("lock_moved",  32'(moved),  32'd0);
        check_val("lock_err",    32'(err),    32'd0);

        // ---------------- forward sweep ----------------
        for (int i = 0; i < 5; i++) begin
            apply(fwd_seq[i]);
            check_val($sformatf("fwd%0d_pos", i),   32'(pos),   32'(fwd_pos[i]));
            check_val($sformatf("fwd%0d_dir", i),   32'(dir),   32'd1);
            check_val($sformatf("fwd%0d_moved", i), 32'(moved), 32'd1);
        end
        check_val("fwd_revs", 32'(revs), 32'd1);
        idle();
        check_val("idle_moved", 32'(moved), 32'd0);
        check_val("idle_pos",   32'(pos),   32'd0);

        // ---------------- reverse sweep: revs 1 -> 0 on 0->4 ----------------
        for (int i = 0; i < 5; i++) begin
            apply(rev_seq[i]);
            check_val($sformatf("rev%0d_pos", i),   32'(pos),   32'(rev_pos[i]));
            check_val($sformatf("rev%0d_dir", i),   32'(dir),   32'd0);
            check_val($sformatf("rev%0d_moved", i), 32'(moved), 32'd1);
        end
        check_val("rev_revs", 32'(revs), 32'd0);

        // ---------------- hold ----------------
        apply(5'b00001);
        check_val("hold_moved", 32'(moved), 32'd0);
        check_val("hold_pos",   32'(pos),   32'd0);
`ifdef RING_HOLD_ERR_EN
        check_val("hold_err",   32'(err),      32'd1);
        check_val("hold_code",  32'(err_code), 32'd2);
`else
        check_val("hold_err",   32'(err),      32'd0);
        check_val("hold_code",  32'(err_code), 32'd0);
`endif

        // ---------------- reverse wrap from zero: revs -> -1 ----------------
        do_reset();
        apply(5'b00001);
        apply(5'b10000);
        check_val("revwrap_pos",  32'(pos),  32'd4);
        check_val("revwrap_revs", 32'(revs), 32'hFF);

        // ---------------- illegal jump, then not-one-hot ----------------
        do_reset();
        apply(5'b00001);
        apply(5'b00100);
        check_val("jump_err",    32'(err),      32'd1);
        check_val("jump_code",   32'(err_code), 32'd2);
        check_val("jump_locked", 32'(locked),   32'd0);
        check_val("jump_pos",    32'(pos),      32'd0);
        apply(5'b00011);
        check_val("both_code",  32'(err_code), 32'd3);
        check_val("both_err",   32'(err),      32'd1);
        check_val("both_pos",   32'(pos),      32'd0);
        check_val("both_moved", 32'(moved),    32'd0);
        // A legal neighbour does not move out of FAULT.
        apply(5'b00010);
        check_val("fault_pos",   32'(pos),   32'd0);
        check_val("fault_moved", 32'(moved), 32'd0);

        // ---------------- not-one-hot alone from TRACK ----------------
        do_reset();
        apply(5'b00100);
        apply(5'b00000);
        check_val("zero_code", 32'(err_code), 32'd1);
        check_val("zero_pos",  32'(pos),      32'd2);

        // ---------------- 128 forward revolutions, step held high ----------------
        do_reset();
        apply(5'b00001);
        moved_cnt = 0;
        step = 1'b1;
        for (int k = 0; k < 128 * 5; k++) begin
            ring = fwd_seq[k % 5];
            @(posedge clk);
            #1;
            if (moved === 1'b1) moved_cnt++;
        end
        step = 1'b0;
        $display("128 revs -> revs=%0d pos=%0d moved_cnt=%0d", $signed(revs), pos, moved_cnt);
        check_val("wrap_revs",  32'(revs),  32'h80);
        check_val("wrap_pos",   32'(pos),   32'd0);
        check_val("wrap_moves", 32'(moved_cnt), 32'd640);
        check_val("wrap_err",   32'(err),   32'd0);
        idle();
        check_val("wrap_idle_moved", 32'(moved), 32'd0);

        // ---------------- reset with step mid-sweep ----------------
        do_reset();
        apply(5'b00001);
        apply(5'b00010);
        apply(5'b00100);
        ring = 5'b01000;
        step = 1'b1;
        rst  = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        step = 1'b0;
        check_reset_outs("midrst");
        // SYNC again: the next legal sample re-locks without a pulse.
        apply(5'b01000);
        check_val("relock_pos",    32'(pos),    32'd3);
        check_val("relock_locked", 32'(locked), 32'd1);
        check_val("relock_moved",  32'(moved),  32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_state_decoder.md
# ring_state_decoder

Hardware observer for the five-state one-hot ring controller: samples the controller's one-hot state bus on each step strobe, recovers the binary position and direction of travel, and keeps a signed revolution count. It flags any illegal encoding or illegal transition. It sits beside the ring FSM as the receiving end of its state output, driving status displays and replacing the testbench-side compare logic with synthesizable checking.

## Interface
- `N`, 5: ring length, i.e. the one-hot width; legal range 2..8.
- `REV_W`, 8: revolution counter width.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-low; takes effect on the rising edge where `rst`==0.
- `step`  in  1  sample strobe; `ring` is evaluated only on edges where `step`==1.
- `ring`  in  N  one-hot state from the ring FSM; bit 0 = Sa, bit N-1 = last state.
- `pos`  out  3  binary index of the last legally sampled state.
- `dir`  out  1  1 = last move forward (bit i to bit i+1 mod N); 0 = reverse.
- `moved`  out  1  one-cycle pulse: the last sample was a legal single-step move.
- `revs`  out  REV_W  signed net revolutions, two's complement.
- `locked`  out  1  a legal reference state has been captured.
- `err`  out  1  sticky fault flag.
- `err_code`  out  2  01 = not one-hot, 10 = illegal jump, 11 = both; 00 = none.

## Operation
- Reset values: `pos`=0, `dir`=1, `moved`=0, `revs`=0, `locked`=0, `err`=0, `err_code`=00; state = SYNC.
- A sample is legal one-hot when exactly one bit of `ring` is set.
- SYNC state:
  - On a `step` with legal one-hot: capture `pos`, set `locked`=1, go to TRACK. No `moved` pulse. `revs` unchanged.
  - On a `step` with a non-one-hot sample: stay in SYNC. No error is flagged.
- TRACK state, on each `step`, with p = current `pos` and q = index of the sample:
  - q = (p+1) mod N: forward move. `dir`=1, `moved`=1, `pos`=q. If p=N-1 and q=0, `revs`+=1.
  - q = (p-1) mod N: reverse move. `dir`=0, `moved`=1, `pos`=q. If p=0 and q=N-1, `revs`-=1.
  - q = p: hold. No change and no pulse. Legal by default; see Configuration.
  - Any other q: illegal jump. Go to FAULT with `err_code` bit 1 set.
  - Not one-hot: go to FAULT with `err_code` bit 0 set.
- N=2 corner case: forward and reverse indices coincide. Decode such a move as forward.
- FAULT state:
  - `err`=1 and `locked`=0.
  - `pos`, `dir` and `revs` are frozen at their last legal values; `moved`=0.
  - Further faults OR additional bits into `err_code`.
  - Only reset exits FAULT.
- `revs` wraps modulo 2^REV_W in both directions and never saturates.
- With `step`=0, no state or output changes, except that `moved` returns to 0.

## Timing
- Single-cycle latency: `ring` is sampled on edge k with `step`=1, and outputs reflect it after edge k.
- `moved` is high for exactly one cycle per legal move, even when `step` is held high continuously. With continuous `step`, every edge is evaluated.
- Reset dominates `step` on the same edge: all outputs return to reset values and state returns to SYNC.
- Reset mid-revolution discards `revs`. The next legal sample re-locks at whatever position it carries.
- `err` asserts on the edge that samples the faulty value.
- No combinational path from inputs to outputs.

## Configuration
- `RING_HOLD_ERR_EN`:
  - Defined: in TRACK, a `step` that samples the same state (q = p) is an illegal jump (`err_code` bit 1). Use this when `step` is tied to the FSM's clock-advance strobe.
  - Not defined: hold is legal and silent.
  - SYNC and FAULT behaviour is identical in both builds.

## Test plan
- Reset, then `step` with `ring`=00001 → after one edge `locked`=1, `pos`=0, `moved`=0, `err`=0.
- Forward sweep 00001→00010→00100→01000→10000→00001, one `step` each → `pos` 1,2,3,4,0; `dir`=1; five `moved` pulses; `revs`=1 after the last.
- From `pos`=0, reverse to 10000, then down to 00001 → `dir`=0, `pos` 4,3,2,1,0; `revs` decremented once on the 0→4 move (1→0, or 0→-1 when starting from zero).
- From `pos`=0, sample 00100 → `err`=1, `err_code`=10, `locked`=0, `pos` frozen at 0. A later sample of 00011 → `err_code`=11.
- Repeat 00001 twice in TRACK → default build: no error, no pulse. With `RING_HOLD_ERR_EN`: `err`=1, `err_code`=10.
- Wrap tests, each after reset:
  - 128 forward revolutions (REV_W=8) → `revs`=-128.
  - Assert `rst`=0 together with `step` mid-sweep → all outputs at reset values; state SYNC.
